// File: rtl/rtc_apb_regs_pkg.sv
// rtc_apb_regs_pkg: register word offsets, peripheral ID bytes and count type.
// Rev 1.0
`default_nettype none

package rtc_apb_regs_pkg;

  typedef logic [31:0] count_t;

  // Word addresses, i.e. byte offset >> 2
  localparam logic [9:0] C_ADDR_DR   = 10'h000;
  localparam logic [9:0] C_ADDR_MR   = 10'h001;
  localparam logic [9:0] C_ADDR_LR   = 10'h002;
  localparam logic [9:0] C_ADDR_CR   = 10'h003;
  localparam logic [9:0] C_ADDR_IMSC = 10'h004;
  localparam logic [9:0] C_ADDR_RIS  = 10'h005;
  localparam logic [9:0] C_ADDR_MIS  = 10'h006;
  localparam logic [9:0] C_ADDR_ICR  = 10'h007;
  localparam logic [9:0] C_ADDR_PID0 = 10'h3F8;
  localparam logic [9:0] C_ADDR_PID1 = 10'h3F9;
  localparam logic [9:0] C_ADDR_PID2 = 10'h3FA;
  localparam logic [9:0] C_ADDR_PID3 = 10'h3FB;
  localparam logic [9:0] C_ADDR_CID0 = 10'h3FC;
  localparam logic [9:0] C_ADDR_CID1 = 10'h3FD;
  localparam logic [9:0] C_ADDR_CID2 = 10'h3FE;
  localparam logic [9:0] C_ADDR_CID3 = 10'h3FF;

  localparam logic [7:0] C_PID0      = 8'h31;
  localparam logic [7:0] C_PID1      = 8'h10;
  localparam logic [3:0] C_PID2_LO   = 4'h4;
  localparam logic [7:0] C_PID3      = 8'h00;
  localparam logic [7:0] C_CID0      = 8'h0D;
  localparam logic [7:0] C_CID1      = 8'hF0;
  localparam logic [7:0] C_CID2      = 8'h05;
  localparam logic [7:0] C_CID3      = 8'hB1;

endpackage

`default_nettype wire

// File: rtl/rtc_apb_regs_if.sv
// rtc_apb_regs_if: APB bus signals shared by the requester and the RTC registers.
// Rev 1.0
`default_nettype none

interface rtc_apb_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA);
endinterface

`default_nettype wire

// File: rtl/rtc_counter.sv
// rtc_counter: 32-bit seconds counter with load, wrap and post-update match pulse.
// Rev 1.0
`default_nettype none

module rtc_counter
  import rtc_apb_regs_pkg::*;
(
  input  wire logic   PCLK,
  input  wire logic   PRESETn,
  input  wire logic   i_tick,
  input  wire logic   i_en,
  input  wire logic   i_load,
  input  wire count_t i_load_val,
  input  wire count_t i_match_val,
  output count_t      o_count,
  output logic        o_match
);

  count_t r_count;
  logic   r_upd;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_count <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= i_load | (i_tick & i_en);
      // Load has priority over a coincident tick
      if (i_load)
        r_count <= i_load_val;
      else if (i_tick && i_en)
        r_count <= r_count + 32'd1;
    end
  end

  // Compared in the cycle after the update so RIS sets one edge later
  assign o_match = r_upd && (r_count == i_match_val);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/rtc_apb_regs.sv
// rtc_apb_regs: APB register block of the RTC with decode, control registers and read mux.
// Rev 1.0
`default_nettype none

module rtc_apb_regs
  import rtc_apb_regs_pkg::*;
(
  input  wire logic        PCLK,
  input  wire logic        PRESETn,
  rtc_apb_regs_if.slave    apb,
  input  wire logic        Tick,
  input  wire logic        Revision,
  output logic             RTCINTR
);

  count_t      r_mr;
  count_t      r_lr;
  logic        r_cr;
  logic        r_imsc;
  logic        r_ris;
  logic        r_intr;
  logic [31:0] r_prdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_wr_lr;
  logic        w_match;
  count_t      w_count;
  logic [31:0] w_rdata;

  assign w_wr    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign w_rd    = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign w_wr_lr = w_wr && (apb.PADDR == C_ADDR_LR);

  rtc_counter u_counter (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .i_tick      (Tick),
    .i_en        (r_cr),
    .i_load      (w_wr_lr),
    .i_load_val  (apb.PWDATA),
    .i_match_val (r_mr),
    .o_count     (w_count),
    .o_match     (w_match)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_mr   <= '0;
      r_lr   <= '0;
      r_cr   <= 1'b0;
      r_imsc <= 1'b0;
      r_ris  <= 1'b0;
      r_intr <= 1'b0;
    end else begin
      if (w_wr && (apb.PADDR == C_ADDR_MR))   r_mr   <= apb.PWDATA;
      if (w_wr_lr)                            r_lr   <= apb.PWDATA;
      if (w_wr && (apb.PADDR == C_ADDR_CR))   r_cr   <= apb.PWDATA[0];
      if (w_wr && (apb.PADDR == C_ADDR_IMSC)) r_imsc <= apb.PWDATA[0];
      // A match set outranks a coincident ICR clear
      if (w_match)
        r_ris <= 1'b1;
      else if (w_wr && (apb.PADDR == C_ADDR_ICR) && apb.PWDATA[0])
        r_ris <= 1'b0;
      r_intr <= r_ris & r_imsc;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (apb.PADDR)
      C_ADDR_DR:   w_rdata = w_count;
      C_ADDR_MR:   w_rdata = r_mr;
      C_ADDR_LR:   w_rdata = r_lr;
      C_ADDR_CR:   w_rdata = {31'd0, r_cr};
      C_ADDR_IMSC: w_rdata = {31'd0, r_imsc};
      C_ADDR_RIS:  w_rdata = {31'd0, r_ris};
      C_ADDR_MIS:  w_rdata = {31'd0, r_ris & r_imsc};
      C_ADDR_PID0: w_rdata = {24'd0, C_PID0};
      C_ADDR_PID1: w_rdata = {24'd0, C_PID1};
      C_ADDR_PID2: w_rdata = {24'd0, 3'b000, Revision, C_PID2_LO};
      C_ADDR_PID3: w_rdata = {24'd0, C_PID3};
      C_ADDR_CID0: w_rdata = {24'd0, C_CID0};
      C_ADDR_CID1: w_rdata = {24'd0, C_CID1};
      C_ADDR_CID2: w_rdata = {24'd0, C_CID2};
      C_ADDR_CID3: w_rdata = {24'd0, C_CID3};
      default:     w_rdata = '0;
    endcase
  end

  // Read data is captured in the setup phase and held until the next read
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      r_prdata <= '0;
    else if (w_rd)
      r_prdata <= w_rdata;
  end

  assign apb.PRDATA = r_prdata;
  assign RTCINTR    = r_intr;

endmodule

`default_nettype wire

// File: tb/tb_rtc_apb_regs.sv
// tb_rtc_apb_regs: directed self-checking bench for the RTC APB register block.
// Rev 1.0
`default_nettype none

module tb_rtc_apb_regs;

  logic clk;
  logic rst_n;
  logic tick;
  logic revision;
  logic intr;
  int   n_pass;
  int   n_total;

  rtc_apb_regs_if apb ();

  rtc_apb_regs dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .apb      (apb),
    .Tick     (tick),
    .Revision (revision),
    .RTCINTR  (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0;  apb.PWDATA = '0;
  endtask

  task automatic apb_write(input logic [11:0] off, input logic [31:0] d);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = off[11:2]; apb.PWDATA = d;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic apb_read(input logic [11:0] off, output logic [31:0] d);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = off[11:2];
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    d = apb.PRDATA;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic do_tick();
    @(posedge clk); #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_total++;
    if (apb.PRDATA !== 32'h0) $display("FAIL reset_prdata got=%h exp=%h", apb.PRDATA, 32'h0);
    else n_pass++;
    n_total++;
    if (intr !== 1'b0) $display("FAIL reset_intr got=%b exp=0", intr);
    else n_pass++;
    apb_read(12'h000, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_dr got=%h exp=%h", d, 32'h0);
    else n_pass++;
    apb_read(12'h004, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL reset_mr got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_id();
    logic [31:0] d;
    revision = 1'b1;
    apb_read(12'hFE8, d);
    n_total++;
    if (d !== 32'h14) $display("FAIL id_pid2_rev1 got=%h exp=%h", d, 32'h14);
    else n_pass++;
    revision = 1'b0;
    apb_read(12'hFE8, d);
    n_total++;
    if (d !== 32'h04) $display("FAIL id_pid2_rev0 got=%h exp=%h", d, 32'h04);
    else n_pass++;
    apb_read(12'hFF0, d);
    n_total++;
    if (d !== 32'h0D) $display("FAIL id_cid0 got=%h exp=%h", d, 32'h0D);
    else n_pass++;
    apb_write(12'hFE0, 32'hFFFF_FFFF);
    apb_read(12'hFE0, d);
    n_total++;
    if (d !== 32'h31) $display("FAIL id_pid0_ro got=%h exp=%h", d, 32'h31);
    else n_pass++;
    apb_read(12'hFFC, d);
    n_total++;
    if (d !== 32'hB1) $display("FAIL id_cid3 got=%h exp=%h", d, 32'hB1);
    else n_pass++;
    apb_read(12'h020, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL unmapped_020 got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    apb_write(12'h004, 32'hA5A5_0001);
    apb_read(12'h004, d);
    n_total++;
    if (d !== 32'hA5A5_0001) $display("FAIL mr_rw got=%h exp=%h", d, 32'hA5A5_0001);
    else n_pass++;
    apb_write(12'h008, 32'h0000_1234);
    apb_read(12'h008, d);
    n_total++;
    if (d !== 32'h0000_1234) $display("FAIL lr_rw got=%h exp=%h", d, 32'h0000_1234);
    else n_pass++;
    do_tick();
    apb_read(12'h000, d);
    n_total++;
    if (d !== 32'h0000_1234) $display("FAIL dr_frozen got=%h exp=%h", d, 32'h0000_1234);
    else n_pass++;
    apb_write(12'h01C, 32'h1);
    apb_read(12'h01C, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL icr_reads0 got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [31:0] exp_v [3];
    exp_v[0] = 32'hFFFF_FFFF; exp_v[1] = 32'h0; exp_v[2] = 32'h1;
    apb_write(12'h008, 32'hFFFF_FFFE);
    apb_write(12'h00C, 32'h1);
    apb_read(12'h00C, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL cr_rw got=%h exp=%h", d, 32'h1);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      apb_read(12'h000, d);
      n_total++;
      if (d !== exp_v[i]) $display("FAIL wrap_dr%0d got=%h exp=%h", i, d, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_match();
    logic [31:0] d;
    apb_write(12'h004, 32'h5);
    apb_write(12'h01C, 32'h1);
    apb_write(12'h010, 32'h1);
    apb_write(12'h008, 32'h3);
    @(posedge clk); #1;
    n_total++;
    if (intr !== 1'b0) $display("FAIL match_pre_intr got=%b exp=0", intr);
    else n_pass++;
    do_tick();
    do_tick();
    @(posedge clk); #1;
    n_total++;
    if (intr !== 1'b0) $display("FAIL match_intr_early got=%b exp=0", intr);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (intr !== 1'b1) $display("FAIL match_intr got=%b exp=1", intr);
    else n_pass++;
    apb_read(12'h014, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL match_ris got=%h exp=%h", d, 32'h1);
    else n_pass++;
    apb_read(12'h018, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL match_mis got=%h exp=%h", d, 32'h1);
    else n_pass++;
    apb_write(12'h01C, 32'h1);
    @(posedge clk); #1;
    n_total++;
    if (intr !== 1'b0) $display("FAIL icr_intr got=%b exp=0", intr);
    else n_pass++;
    apb_read(12'h014, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL icr_ris got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_load_vs_tick();
    logic [31:0] d;
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 10'h002; apb.PWDATA = 32'h10;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; bus_idle();
    apb_read(12'h000, d);
    n_total++;
    if (d !== 32'h10) $display("FAIL load_over_tick got=%h exp=%h", d, 32'h10);
    else n_pass++;
    apb_write(12'h004, 32'h10);
    repeat (2) @(posedge clk);
    apb_read(12'h014, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL mr_write_noset got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    apb_write(12'h004, 32'h20);
    apb_write(12'h008, 32'h1F);
    apb_read(12'h014, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL setwin_pre_ris got=%h exp=%h", d, 32'h0);
    else n_pass++;
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 10'h007; apb.PWDATA = 32'h1; tick = 1'b1;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1; tick = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    apb_read(12'h014, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL setwin_ris got=%h exp=%h", d, 32'h1);
    else n_pass++;
    apb_read(12'h000, d);
    n_total++;
    if (d !== 32'h20) $display("FAIL setwin_dr got=%h exp=%h", d, 32'h20);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    n_total++;
    if (intr !== 1'b1) $display("FAIL rstmid_pre_intr got=%b exp=1", intr);
    else n_pass++;
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 10'h002; apb.PWDATA = 32'h55;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (apb.PRDATA !== 32'h0) $display("FAIL rstmid_prdata got=%h exp=%h", apb.PRDATA, 32'h0);
    else n_pass++;
    n_total++;
    if (intr !== 1'b0) $display("FAIL rstmid_intr got=%b exp=0", intr);
    else n_pass++;
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_read(12'h000, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rstmid_dr got=%h exp=%h", d, 32'h0);
    else n_pass++;
    apb_read(12'h008, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rstmid_lr got=%h exp=%h", d, 32'h0);
    else n_pass++;
    apb_read(12'h010, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL rstmid_imsc got=%h exp=%h", d, 32'h0);
    else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    revision = 1'b0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_id();
    test_regs();
    test_wrap();
    test_match();
    test_load_vs_tick();
    test_set_wins();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
